// File: rtl/grf_scoreboard.sv
// Hazard scoreboard for the 32x32 GRF: tracks in-flight writes from multi-cycle
// producers and raises a decode stall on RAW (result not yet forwardable) and WAW conflicts.
module grf_scoreboard #(
    parameter int LAT_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_use_rs,
    input  logic             issue_use_rt,
    input  logic             issue_we,
    input  logic [4:0]       issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    output logic             stall,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [31:0]      busy_reg;
    logic [LAT_W-1:0] cnt_reg [32];
    logic [CNT_W-1:0] stall_cycles_reg;

    logic [31:0] clr;
    logic [31:0] set;
    logic [31:0] cnt_nz;

    logic raw_rs;
    logic raw_rt;
    logic waw;
    logic stall_int;
    logic accept;

    // Per-register decode of writeback clears, issue sets and "still counting down".
    // Register 0 never matches, so it can never become busy.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign clr[gi]    = 1'b0;
                assign set[gi]    = 1'b0;
                assign cnt_nz[gi] = 1'b0;
            end else begin : g_track
                assign clr[gi]    = wb_valid && (wb_addr == 5'(gi));
                assign set[gi]    = accept && (issue_rd == 5'(gi));
                assign cnt_nz[gi] = (cnt_reg[gi] != '0);
            end
        end
    endgenerate

    // A writeback in the same cycle counts as written: the GRF bypasses it to the read port.
    assign raw_rs = issue_use_rs && (issue_rs != 5'd0) && busy_reg[issue_rs]
                    && cnt_nz[issue_rs] && !clr[issue_rs];
    assign raw_rt = issue_use_rt && (issue_rt != 5'd0) && busy_reg[issue_rt]
                    && cnt_nz[issue_rt] && !clr[issue_rt];
    // WAW ignores the countdown so an older writeback can never retire a newer entry.
    assign waw    = issue_we && (issue_rd != 5'd0) && busy_reg[issue_rd] && !clr[issue_rd];

    assign stall_int = issue_valid && (raw_rs || raw_rt || waw);
    assign accept    = issue_valid && !stall_int && issue_we && (issue_rd != 5'd0);

    assign stall        = stall_int && !reset;
    assign busy_vec     = reset ? 32'd0 : busy_reg;
    assign stall_cycles = stall_cycles_reg;

    // Priority per register: new issue, then writeback clear, then countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_reg[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (set[r]) begin
                    busy_reg[r] <= 1'b1;
                    cnt_reg[r]  <= issue_lat;
                end else if (clr[r]) begin
                    busy_reg[r] <= 1'b0;
                    cnt_reg[r]  <= '0;
                end else if (cnt_nz[r]) begin
                    cnt_reg[r]  <= cnt_reg[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (stall_int && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: a table of per-cycle vectors plus hand-written
// sequences for stall counting, saturation (4-bit counter build) and async reset.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    logic        stall;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;
    logic        stall_s;
    logic [31:0] busy_s;
    logic [3:0]  stall_cycles_s;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    grf_scoreboard #(.LAT_W(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .stall(stall), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    grf_scoreboard #(.LAT_W(3), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .stall(stall_s), .busy_vec(busy_s), .stall_cycles(stall_cycles_s)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_rs;
        logic        use_rt;
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  lat;
        logic        wbv;
        logic [4:0]  wba;
        logic        exp_stall;
        logic [31:0] exp_busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid  = v.valid;
        issue_rs     = v.rs;
        issue_rt     = v.rt;
        issue_use_rs = v.use_rs;
        issue_use_rt = v.use_rt;
        issue_we     = v.we;
        issue_rd     = v.rd;
        issue_lat    = v.lat;
        wb_valid     = v.wbv;
        wb_addr      = v.wba;
    endtask

    // One cycle: drive just after the edge, check mid-cycle, then step to the next edge.
    task automatic run_vec(input vec_t v, input string name);
        drive(v);
        #3;
        $display("%s: stall=%0b busy=%h sc=%0d sc4=%0d", name, stall, busy_vec,
                 stall_cycles, stall_cycles_s);
        chk({name, " stall"}, 32'(stall), 32'(v.exp_stall));
        chk({name, " busy"}, busy_vec, v.exp_busy);
        chk({name, " sc"}, stall_cycles, 32'(exp_sc));
        chk({name, " sc4"}, 32'(stall_cycles_s), 32'((exp_sc > 15) ? 15 : exp_sc));
        if (v.exp_stall) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    localparam vec_t IDLE = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0,
                              1'b0, 32'h0};

    vec_t tbl [22];
    vec_t v;

    initial begin
        //          valid rs rt urs urt we rd lat wbv wba  stall busy
        tbl[0]  = '{0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0};
        tbl[1]  = '{1,  0, 0, 0, 0, 1,  8, 2, 0,  0, 0, 32'h0};        // lw r8, lat 2
        tbl[2]  = '{1,  8, 0, 1, 0, 1, 10, 0, 0,  0, 1, 32'h100};      // cnt8=2
        tbl[3]  = '{1,  8, 0, 1, 0, 1, 10, 0, 0,  0, 1, 32'h100};      // cnt8=1
        tbl[4]  = '{1,  8, 0, 1, 0, 1, 10, 0, 0,  0, 0, 32'h100};      // cnt8=0, accept r10 lat0
        tbl[5]  = '{0,  0, 0, 0, 0, 0,  0, 0, 1,  8, 0, 32'h500};
        tbl[6]  = '{0,  0, 0, 0, 0, 0,  0, 0, 1, 10, 0, 32'h400};
        tbl[7]  = '{0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0};
        tbl[8]  = '{1,  0, 0, 0, 0, 1,  9, 3, 0,  0, 0, 32'h0};        // r9 lat 3
        tbl[9]  = '{1,  0, 9, 0, 1, 0,  0, 0, 0,  0, 1, 32'h200};
        tbl[10] = '{1,  0, 9, 0, 1, 0,  0, 0, 1,  9, 0, 32'h200};      // clear bypasses RAW
        tbl[11] = '{0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0};
        tbl[12] = '{1,  0, 0, 0, 0, 1,  5, 3, 0,  0, 0, 32'h0};        // r5 lat 3
        tbl[13] = '{1,  0, 0, 0, 0, 1,  5, 1, 0,  0, 1, 32'h20};       // WAW
        tbl[14] = '{1,  0, 0, 0, 0, 1,  5, 1, 0,  0, 1, 32'h20};
        tbl[15] = '{1,  0, 0, 0, 0, 1,  5, 1, 1,  5, 0, 32'h20};       // clear+set, set wins
        tbl[16] = '{1,  5, 0, 1, 0, 0,  0, 0, 0,  0, 1, 32'h20};       // new cnt5=1
        tbl[17] = '{1,  5, 0, 1, 0, 0,  0, 0, 0,  0, 0, 32'h20};       // cnt5=0
        tbl[18] = '{0,  0, 0, 0, 0, 0,  0, 0, 1,  5, 0, 32'h20};
        tbl[19] = '{1,  0, 0, 1, 1, 1,  0, 3, 1,  0, 0, 32'h0};        // all-zero registers
        tbl[20] = '{0,  0, 0, 0, 0, 0,  0, 0, 1, 12, 0, 32'h0};        // wb to idle reg
        tbl[21] = '{0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0};

        drive(IDLE);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy_vec, 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset sc", stall_cycles, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Synchronous-point reset clears the counters before the stall-count sequence.
        reset = 1'b1;
        #3;
        chk("rst2 sc", stall_cycles, 32'h0);
        chk("rst2 sc4", 32'(stall_cycles_s), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_sc = 0;

        v = '{1, 0, 0, 0, 0, 1, 20, 7, 0, 0, 0, 32'h0};
        run_vec(v, "r20 issue");
        v = '{1, 20, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h100000};
        for (int i = 0; i < 4; i++) run_vec(v, $sformatf("raw20 %0d", i));
        run_vec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100000}, "sc=4");
        v = '{1, 0, 0, 0, 0, 1, 20, 1, 0, 0, 1, 32'h100000};
        for (int i = 0; i < 14; i++) run_vec(v, $sformatf("waw20 %0d", i));
        run_vec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100000}, "sc=18 sat");
        run_vec('{0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 32'h100000}, "wb20");
        run_vec(IDLE, "idle");

        // Asynchronous reset between edges with several entries pending and a live stall.
        run_vec('{1, 0, 0, 0, 0, 1, 3, 4, 0, 0, 0, 32'h0}, "r3 issue");
        run_vec('{1, 0, 0, 0, 0, 1, 7, 4, 0, 0, 0, 32'h8}, "r7 issue");
        run_vec('{1, 0, 0, 0, 0, 1, 31, 4, 0, 0, 0, 32'h88}, "r31 issue");
        drive('{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0});
        #2;
        chk("pre-arst stall", 32'(stall), 32'h1);
        chk("pre-arst busy", busy_vec, 32'h80000088);
        reset = 1'b1;
        #1;
        $display("async reset: stall=%0b busy=%h sc=%0d", stall, busy_vec, stall_cycles);
        chk("arst busy", busy_vec, 32'h0);
        chk("arst stall", 32'(stall), 32'h0);
        chk("arst sc", stall_cycles, 32'h0);
        chk("arst sc4", 32'(stall_cycles_s), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_sc = 0;
        run_vec('{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0}, "post-arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
